dcache_mem_responder: RTL and testbench

Memory-side responder for the data-cache bus (`dREN`/`dWEN`/`daddr`/`dstore` in, `dwait`/`dload` out). It stands in for the memory controller plus RAM on the far end of the dcache interface. It holds a word-addressed backing store and stalls each request for a programmable number of cycles. Each word-transfer completes with a single-cycle `dwait` low. Used as the dcache's bus partner in unit and integration benches, and as a latency-accurate memory model.

---
 rtl/dcache_mem_responder_if.sv | 24 ++
 rtl/dcache_mem_responder.sv | 116 +++++++++++
 tb/tb_dcache_mem_responder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_responder_if.sv
// Data-cache bus between a dcache (master) and its memory-side partner (slave).
//   dREN / dWEN : read / write request, held by the master until acknowledged
//   daddr       : byte address
//   dstore      : write data, valid while dWEN
//   dwait       : low only in the acknowledge cycle of a matching request
//   dload       : read data, valid only while dwait is low on a read
interface dcache_mem_responder_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport master (
    output dREN, dWEN, daddr, dstore,
    input  dwait, dload
  );

  modport slave (
    input  dREN, dWEN, daddr, dstore,
    output dwait, dload
  );
endinterface

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the dcache bus: a word-addressed backing store that
// stalls every word request for LAT cycles and then acknowledges it with a
// single-cycle dwait low.
//   CLK       : clock, all state on the rising edge
//   nRST      : synchronous active-low reset (clears state, counters and store)
//   bus       : dcache bus, slave side
//   rd_count  : completed reads since reset
//   wr_count  : completed writes since reset
//   proto_err : sticky, set whenever dREN and dWEN are seen high together
module dcache_mem_responder #(
  parameter int unsigned LAT = 2,   // wait cycles per word, 1..15
  parameter int unsigned AW  = 10   // word-address width
) (
  input  logic                  CLK,
  input  logic                  nRST,
  dcache_mem_responder_if.slave bus,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count,
  output logic                  proto_err
);

  localparam int unsigned Depth   = 1 << AW;
  localparam logic [3:0]  LastCnt = 4'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  state_e          st_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   l_addr_q;
  logic            l_wr_q;
  logic [31:0]     rd_count_q;
  logic [31:0]     wr_count_q;
  logic            proto_err_q;
  logic [31:0]     mem_q [Depth];

  logic [AW-1:0]   req_addr;
  logic            req_any;
  logic            req_both;
  logic            op_held;
  logic            match;
  logic            ack;
  logic            unused_addr;

  // Only the word-select bits matter; the rest alias (wrap-around).
  assign req_addr    = bus.daddr[AW+1:2];
  assign unused_addr = ^{bus.daddr[31:AW+2], bus.daddr[1:0]};

  assign req_any  = bus.dREN | bus.dWEN;
  assign req_both = bus.dREN & bus.dWEN;

  always_comb begin
    op_held = l_wr_q ? bus.dWEN : bus.dREN;
    match   = op_held && (req_addr == l_addr_q);
    // Gated by nRST so the bus reads idle while reset is held.
    ack     = nRST && (st_q == StAck) && match;
  end

  assign bus.dwait = ~ack;
  assign bus.dload = (ack && !l_wr_q) ? mem_q[l_addr_q] : 32'h0;

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign proto_err = proto_err_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      l_addr_q    <= '0;
      l_wr_q      <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (req_both) begin
        proto_err_q <= 1'b1;
      end
      case (st_q)
        StIdle: begin
          if (req_any) begin
            l_addr_q <= req_addr;
            l_wr_q   <= bus.dWEN;  // write wins when both are high
            cnt_q    <= '0;
            st_q     <= StBusy;
          end
        end
        StBusy: begin
          if (!match) begin
            st_q <= StIdle;        // request withdrawn or moved: silent abort
          end else if (cnt_q == LastCnt) begin
            st_q <= StAck;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StAck: begin
          if (match) begin
            if (l_wr_q) begin
              // Live dstore is committed, so data changed during the stall wins.
              mem_q[l_addr_q] <= bus.dstore;
              wr_count_q      <= wr_count_q + 32'd1;
            end else begin
              rd_count_q <= rd_count_q + 32'd1;
            end
          end
          st_q <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
module tb_dcache_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        nrst;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic        proto_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dcache_mem_responder_if bus ();

  dcache_mem_responder #(
    .LAT (LAT),
    .AW  (10)
  ) dut (
    .CLK       (clk),
    .nRST      (nrst),
    .bus       (bus),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the request already driven (cycle 0).
  // Returns the relative cycle of the acknowledge, the sampled dload and the
  // absolute cycle; drops the request after the acknowledge edge.
  task automatic wait_ack(output int k, output logic [31:0] ld, output int at);
    k  = -1;
    ld = '0;
    at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.dwait === 1'b0) begin
        k  = i;
        ld = bus.dload;
        at = cyc;
        break;
      end
      step();
    end
    if (k >= 0) step();
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  task automatic xfer(input string tag, input bit ren, input bit wen, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] exp_load, output int at);
    int          k;
    logic [31:0] ld;
    bus.dREN   = ren;
    bus.dWEN   = wen;
    bus.daddr  = addr;
    bus.dstore = data;
    wait_ack(k, ld, at);
    chk({tag, "_lat"}, k, LAT + 1);
    if (!wen) chk({tag, "_data"}, ld, exp_load);
  endtask

  initial begin
    int          k;
    int          a0, a1, a2, a3;
    logic [31:0] ld;

    nrst       = 1'b0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.daddr  = '0;
    bus.dstore = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("rst_dload", bus.dload, 32'h0);
    nrst = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("post_rst_rd", rd_count, 32'd0);
    chk("post_rst_wr", wr_count, 32'd0);
    chk("post_rst_perr", {31'd0, proto_err}, 32'd0);
    step();

    // Read of an unwritten word after reset.
    xfer("rd40", 1, 0, 32'h40, 32'h0, 32'h0, a0);
    chk("rd40_cnt", rd_count, 32'd1);

    // Write then read back.
    xfer("wr100", 0, 1, 32'h100, 32'hDEADBEEF, 32'h0, a0);
    chk("wr100_cnt", wr_count, 32'd1);
    xfer("rd100", 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, a0);
    chk("rd100_cnt", rd_count, 32'd2);

    // Aliasing and ignored byte offset.
    xfer("wr1004", 0, 1, 32'h1004, 32'h11111111, 32'h0, a0);
    xfer("rd0004", 1, 0, 32'h0004, 32'h0, 32'h11111111, a0);
    xfer("rd1007", 1, 0, 32'h1007, 32'h0, 32'h11111111, a0);
    chk("alias_rd_cnt", rd_count, 32'd4);
    chk("alias_wr_cnt", wr_count, 32'd2);

    // Abort: address moves in cycle 2, new word acked 3 cycles after IDLE (cycle 6).
    bus.dREN  = 1'b1;
    bus.daddr = 32'h20;
    @(negedge clk);
    chk("abort_c0_dwait", {31'd0, bus.dwait}, 32'd1);
    step();
    @(negedge clk);
    chk("abort_c1_dwait", {31'd0, bus.dwait}, 32'd1);
    step();
    bus.daddr = 32'h24;
    wait_ack(k, ld, a0);
    chk("abort_lat", k, 32'd4);
    chk("abort_data", ld, 32'h0);
    chk("abort_rd_cnt", rd_count, 32'd5);

    // Writeback of two words then a two-word fill, back to back.
    xfer("ev_w0", 0, 1, 32'h200, 32'hAAAA0200, 32'h0, a0);
    xfer("ev_w1", 0, 1, 32'h204, 32'hBBBB0204, 32'h0, a1);
    xfer("ev_r0", 1, 0, 32'h300, 32'h0, 32'h0, a2);
    xfer("ev_r1", 1, 0, 32'h304, 32'h0, 32'h0, a3);
    chk("ev_gap01", a1 - a0, LAT + 2);
    chk("ev_gap12", a2 - a1, LAT + 2);
    chk("ev_gap23", a3 - a2, LAT + 2);
    chk("ev_wr_cnt", wr_count, 32'd4);
    chk("ev_rd_cnt", rd_count, 32'd7);
    xfer("ev_chk204", 1, 0, 32'h204, 32'h0, 32'hBBBB0204, a0);

    // Both requests high: flagged, handled as a write.
    chk("perr_before", {31'd0, proto_err}, 32'd0);
    xfer("both80", 1, 1, 32'h80, 32'h5, 32'h0, a0);
    chk("perr_set", {31'd0, proto_err}, 32'd1);
    chk("both_wr_cnt", wr_count, 32'd5);
    xfer("rd80", 1, 0, 32'h80, 32'h0, 32'h5, a0);
    chk("perr_sticky", {31'd0, proto_err}, 32'd1);
    chk("rd80_cnt", rd_count, 32'd9);

    // Reset pulse while a write is in BUSY: nothing survives.
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h84;
    bus.dstore = 32'h7;
    step();
    nrst = 1'b0;
    @(negedge clk);
    chk("mid_rst_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("mid_rst_dload", bus.dload, 32'h0);
    step();
    nrst     = 1'b1;
    bus.dWEN = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd", rd_count, 32'd0);
    chk("mid_rst_wr", wr_count, 32'd0);
    chk("mid_rst_perr", {31'd0, proto_err}, 32'd0);
    step();
    xfer("rst_rd80", 1, 0, 32'h80, 32'h0, 32'h0, a0);
    xfer("rst_rd84", 1, 0, 32'h84, 32'h0, 32'h0, a0);
    chk("final_rd_cnt", rd_count, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
